// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 modified-Booth significand multiplier.
// Accepts two unsigned N-bit significands, retires one Booth digit per cycle and
// returns the exact 2N-bit product. Both sides use valid/ready handshakes.
//
// Handshake rule (both ports): a transfer happens on a rising clock edge where
// valid && ready are both high. in_ready/out_valid come straight from the state
// register, so neither depends combinationally on in_valid or out_ready.
module booth_seq_multiplier #(
  parameter int SIG_WIDTH = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIG_WIDTH:0]         a_sig,
  input  logic [SIG_WIDTH:0]         b_sig,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*(SIG_WIDTH+1)-1:0] product,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int N      = SIG_WIDTH + 1;
  localparam int DIGITS = (N + 2) / 2;       // ceil((N+1)/2)
  localparam int BW     = SIG_WIDTH + 3;     // signed multiple width (holds +-2b)
  localparam int AW     = 2 * N + 4;         // accumulator width
  localparam int MW     = N + 2;             // multiplier with guard bits
  localparam int CW     = $clog2(DIGITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        [MW-1:0]  mult_q;    // remaining multiplier bits, triplet in [2:0]
  logic signed [BW-1:0]  b_q, mb_q, tb_q, mtb_q;
  logic signed [AW-1:0]  acc_q;
  logic        [CW-1:0]  cnt_q;
  logic        [2*N-1:0] product_q;

  logic                  accept;
  logic                  last_digit;
  logic signed [BW-1:0]  sel;
  logic signed [AW-1:0]  pp;
  logic signed [AW-1:0]  acc_next;

  // Modified-Booth recoder: triplet {a[2i+1], a[2i], a[2i-1]} -> digit in {-2..2},
  // returned as one-hot {neg2, neg1, pos1, pos2}; all zero means digit 0.
  function automatic logic [3:0] booth_recode(input logic [2:0] t);
    logic [3:0] r;
    r = 4'b0000;
    case (t)
      3'b001, 3'b010: r = 4'b0010;   // +b
      3'b011:         r = 4'b0001;   // +2b
      3'b100:         r = 4'b1000;   // -2b
      3'b101, 3'b110: r = 4'b0100;   // -b
      default:        r = 4'b0000;   // 000, 111 -> 0
    endcase
    return r;
  endfunction

  assign accept     = (state_q == S_IDLE) && in_valid;
  assign last_digit = (cnt_q == CW'(DIGITS - 1));

  // Partial product for the current digit: select multiple, sign-extend, shift by 2i.
  always_comb begin
    logic [3:0] dig;
    dig = booth_recode(mult_q[2:0]);
    sel = '0;
    unique case (1'b1)
      dig[0]:  sel = tb_q;
      dig[1]:  sel = b_q;
      dig[2]:  sel = mb_q;
      dig[3]:  sel = mtb_q;
      default: sel = '0;
    endcase
    pp       = {{(AW-BW){sel[BW-1]}}, sel} <<< {cnt_q, 1'b0};
    acc_next = acc_q + pp;
  end

  // Next-state logic; status outputs are pure decodes of the current state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (last_digit) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: capture operands and multiples on accept, accumulate one digit per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_q    <= '0;
      b_q       <= '0;
      mb_q      <= '0;
      tb_q      <= '0;
      mtb_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mult_q <= {1'b0, a_sig, 1'b0};
      b_q    <= BW'(b_sig);
      mb_q   <= -BW'(b_sig);
      tb_q   <= BW'(b_sig) <<< 1;
      mtb_q  <= -(BW'(b_sig) <<< 1);
      acc_q  <= '0;
      cnt_q  <= '0;
    end else if (state_q == S_BUSY) begin
      acc_q  <= acc_next;
      mult_q <= mult_q >> 2;
      cnt_q  <= cnt_q + CW'(1);
      if (last_digit) product_q <= acc_next[2*N-1:0];
    end
  end

  assign product   = product_q;
  assign dbg_state = state_q;

endmodule
